cpu_stack: RTL and testbench
============================

# cpu_stack

Hardware operand stack that consumes the stage-5a push stream (`st__push_5a` / `st__to_push_5a`) and serves top-of-stack pops to stage 2a. It sits directly downstream of the writeback push path and upstream of the operand-fetch stage. It raises `stall_2a` when 2a needs an operand that does not yet exist. It forwards a same-cycle 5a push straight to 2a, so back-to-back push/pop never stalls.

## Interface
Parameters:
- `WIDTH`, 35: entry width in bits; matches `st__to_push_5a`.
- `DEPTH`, 16: number of entries; must be at least 2.
- `DW`, `$clog2(DEPTH+1)`: width of the depth count.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `st__push_5a`, in, 1: push request from stage 5a.
- `st__to_push_5a`, in, WIDTH: value to push.
- `st__pop_2a`, in, 1: stage 2a consumes the top of stack this cycle.
- `st__clear`, in, 1: synchronous flush of all entries (exception/restart).
- `st__top_2a`, out, WIDTH: current top-of-stack as seen by 2a (combinational).
- `st__valid_2a`, out, 1: `st__top_2a` holds a real operand.
- `stall_2a`, out, 1: this block's stall contribution to 2a; ORed elsewhere.
- `st__depth`, out, DW: registered entry count, range 0..DEPTH.
- `st__overflow`, out, 1: sticky flag; set when a push is dropped.

## Operation
- Storage: register array `mem[0..DEPTH-1]` plus pointer `sp` (0..DEPTH). `sp` is the count; the top is `mem[sp-1]`. The array is not reset.
- Program order: a 5a push is older than the 2a pop in the same cycle, so the push is logically first.
- Combinational outputs:
  - `st__top_2a` = `st__to_push_5a` if `st__push_5a`.
  - Otherwise `st__top_2a` = `mem[sp-1]` if `sp>0`.
  - Otherwise `st__top_2a` = 0. It must be 0, not X, when invalid.
  - `st__valid_2a` = `st__push_5a | (sp!=0)`.
  - `stall_2a` = `st__pop_2a & ~st__valid_2a`.
- Clock-edge update, evaluated in priority order:
  - `st__clear`: `sp`←0. Push and pop in that cycle are ignored. `st__overflow` is unchanged.
  - push & pop (forwarded): the pop takes the pushed value. `mem` and `sp` are unchanged. No overflow, even at `sp==DEPTH`.
  - push only, `sp<DEPTH`: `mem[sp]`←data, `sp`←`sp+1`.
  - push only, `sp==DEPTH`: data is dropped, `sp` is unchanged, `st__overflow`←1.
  - pop only, `sp>0`: `sp`←`sp-1`.
  - pop only, `sp==0`: this is a stall. No state change.
- `st__overflow` is cleared only by `rst`.
- `st__depth` = `sp`, registered.

## Timing
- Reset values: `sp`=0 and `st__overflow`=0. Therefore `st__depth`=0, `st__valid_2a`=0 (absent a push), `st__top_2a`=0, and `stall_2a`=`st__pop_2a`.
- Reset is asynchronous. Asserting `rst` mid-sequence zeroes `sp` and `st__overflow` immediately, without waiting for a clock edge. The first edge after deassertion operates normally.
- Pop/top: zero latency. `st__top_2a` is valid in the same cycle `st__pop_2a` is sampled; the pop commits at the next edge.
- Push: one-cycle latency to storage. The pushed value is the registered top in the cycle after the edge; in the push cycle itself it is reached by forwarding.
- Stall handshake:
  - A stalled pop is not consumed.
  - 2a must hold `st__pop_2a` high until `stall_2a` falls.
  - The stall releases in the same cycle a push arrives, through forwarding.
- There is no combinational path from `st__pop_2a` to `st__top_2a` or `st__valid_2a`. The only path from `st__pop_2a` is to `stall_2a`.
- Wrap-around cannot occur: the pointer saturates at 0 and at DEPTH.

## Test plan
- Reset, then push 0x1, 0x2, 0x3 in consecutive cycles, then pop ×3 -> `st__top_2a` reads 0x3, 0x2, 0x1; `st__depth` goes 1, 2, 3, 2, 1, 0; `stall_2a`=0 throughout.
- Empty stack, hold pop for 3 cycles, then push 0x7_DEAD_BEEF with pop still high -> `stall_2a`=1 for 3 cycles, then 0 in the push cycle; `st__top_2a`=0x7_DEAD_BEEF in that cycle; `st__depth` stays 0 after the edge.
- Push 17 distinct values with DEPTH=16 -> `st__depth`=16 and `st__overflow`=1 after the 17th; popping 16 times returns values 16..1 in LIFO order, and the 17th value is never seen.
- At `sp==16`, push 0x55 and pop in the same cycle -> `st__top_2a`=0x55 in that cycle, `st__depth` stays 16, `st__overflow` stays 0; the next pop returns the 16th value.
- Depth 5 with `st__clear` plus a push in the same cycle -> depth 0 on the next cycle, `st__valid_2a`=0, `st__top_2a`=0; `st__overflow` is retained.
- Depth 4 and overflow set, assert `rst` between clock edges -> `st__depth`=0 and `st__overflow`=0 before the next edge; after release, push 0x9 then pop returns 0x9.

Source files
------------

// File: rtl/cpu_stack.sv
`default_nettype none
// ============================================================================
// Module   : cpu_stack
// Brief    : Operand stack fed by the 5a push stream, serving top-of-stack
//            pops to 2a with same-cycle push forwarding and stall generation.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_stack #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st__push_5a,
  input  logic [WIDTH-1:0] st__to_push_5a,
  input  logic             st__pop_2a,
  input  logic             st__clear,
  output logic [WIDTH-1:0] st__top_2a,
  output logic             st__valid_2a,
  output logic             stall_2a,
  output logic [DW-1:0]    st__depth,
  output logic             st__overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_sp;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_top;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == DW'(DEPTH));
  assign w_top_idx = AW'(r_sp - DW'(1));
  assign w_wr_idx  = AW'(r_sp);

  // A push paired with a pop is consumed by forwarding and never stored.
  assign w_wr_en = st__push_5a & ~st__pop_2a & ~st__clear & ~w_full;

  // Top depends only on the push side and stored state, never on the pop.
  always_comb begin
    w_top = '0;
    if (st__push_5a)
      w_top = st__to_push_5a;
    else if (!w_empty)
      w_top = r_mem[w_top_idx];
  end

  assign st__top_2a   = w_top;
  assign st__valid_2a = st__push_5a | ~w_empty;
  assign stall_2a     = st__pop_2a & ~st__valid_2a;
  assign st__depth    = r_sp;
  assign st__overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp       <= '0;
      r_overflow <= 1'b0;
    end else if (st__clear) begin
      r_sp <= '0;
    end else if (st__push_5a && !st__pop_2a) begin
      if (w_full)
        r_overflow <= 1'b1;
      else
        r_sp <= r_sp + DW'(1);
    end else if (st__pop_2a && !st__push_5a && !w_empty) begin
      r_sp <= r_sp - DW'(1);
    end
  end

  // Storage is deliberately left unreset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_wr_idx] <= st__to_push_5a;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_stack
// Brief    : Scoreboard bench for cpu_stack against a queue-based stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_stack;

  localparam int WIDTH = 35;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] data;
  logic             pop;
  logic             clr;
  logic [WIDTH-1:0] top;
  logic             valid;
  logic             stall;
  logic [DW-1:0]    depth;
  logic             ovf;

  cpu_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .st__push_5a    (push),
    .st__to_push_5a (data),
    .st__pop_2a     (pop),
    .st__clear      (clr),
    .st__top_2a     (top),
    .st__valid_2a   (valid),
    .stall_2a       (stall),
    .st__depth      (depth),
    .st__overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] top;
    bit               valid;
    bit               stall;
    int               depth;
    bit               ovf;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model[$];
  bit               model_ovf;
  int               n_checks;
  int               n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus, record the expected view, then advance the model.
  task automatic step(input bit p, input logic [WIDTH-1:0] d, input bit po,
                      input bit c, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; push = p; data = d; pop = po; clr = c;
    if (r) begin
      model.delete();
      model_ovf = 1'b0;
    end
    e.top   = p ? d : (model.size() > 0 ? model[model.size()-1] : '0);
    e.valid = p || (model.size() > 0);
    e.stall = po && !e.valid;
    e.depth = model.size();
    e.ovf   = model_ovf;
    sb.push_back(e);
    if (!r) begin
      if (c) model.delete();
      else if (p && !po) begin
        if (model.size() < DEPTH) model.push_back(d);
        else model_ovf = 1'b1;
      end else if (po && !p && model.size() > 0) begin
        void'(model.pop_back());
      end
    end
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("top",      64'(top),   64'(e.top));
      chk("valid",    64'(valid), 64'(e.valid));
      chk("stall",    64'(stall), 64'(e.stall));
      chk("depth",    64'(depth), 64'(e.depth));
      chk("overflow", 64'(ovf),   64'(e.ovf));
    end
  end

  initial begin
    n_checks = 0; n_pass = 0; model_ovf = 1'b0;
    rst = 1'b1; push = 1'b0; data = '0; pop = 1'b0; clr = 1'b0;
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    idle();

    // LIFO ordering
    step(1, 35'h1, 0, 0, 0);
    step(1, 35'h2, 0, 0, 0);
    step(1, 35'h3, 0, 0, 0);
    repeat (3) step(0, '0, 1, 0, 0);
    idle();

    // Stalled pop released by a forwarded push
    repeat (3) step(0, '0, 1, 0, 0);
    step(1, 35'h7_DEAD_BEEF, 1, 0, 0);
    idle();

    // Overflow on the 17th push, then drain
    for (int i = 1; i <= DEPTH + 1; i++) step(1, WIDTH'(i), 0, 0, 0);
    repeat (DEPTH) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // Clear with a same-cycle push; overflow is retained
    for (int i = 0; i < 5; i++) step(1, WIDTH'(35'h100 + i), 0, 0, 0);
    step(1, 35'h1FF, 0, 1, 0);
    idle();

    // Asynchronous reset mid-cycle at depth 4 with overflow set
    for (int i = 0; i < 4; i++) step(1, WIDTH'(35'h200 + i), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(1, 35'h9, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    idle();

    // Forwarded push/pop at full depth does not overflow
    for (int i = 1; i <= DEPTH; i++) step(1, WIDTH'(35'h300 + i), 0, 0, 0);
    step(1, 35'h55, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    idle();

    // Randomized traffic, push-heavy first then pop-heavy
    for (int i = 0; i < 1500; i++) begin
      int pp;
      pp = (i < 500) ? 70 : ((i < 1000) ? 30 : 50);
      step($urandom_range(99, 0) < pp,
           WIDTH'({$urandom(), $urandom()}),
           $urandom_range(99, 0) < (100 - pp),
           $urandom_range(99, 0) < 2,
           $urandom_range(199, 0) == 0);
    end

    idle();
    @(posedge clk);
    @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
